// File: rtl/data_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_ram                                                        |
// | Purpose  : True dual-port, byte-writable 32-bit data memory, read-first,   |
// |            one-cycle registered reads; port B wins same-lane collisions.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module data_ram #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  wea,
   input  logic [29:0] addra,
   input  logic [31:0] dina,
   output logic [31:0] douta,
   input  logic [3:0]  web,
   input  logic [29:0] addrb,
   input  logic [31:0] dinb,
   output logic [31:0] doutb
);

   localparam int c_DEPTH = 1 << ADDR_WIDTH;
   localparam int c_LANES = 4;

   logic [ADDR_WIDTH-1:0] w_idx_a;
   logic [ADDR_WIDTH-1:0] w_idx_b;

   // Upper address bits are deliberately ignored so addresses wrap modulo depth.
   assign w_idx_a = addra[ADDR_WIDTH-1:0];
   assign w_idx_b = addrb[ADDR_WIDTH-1:0];

   generate
      if (ADDR_WIDTH < 30) begin : g_upper_addr
         logic w_unused_upper;
         assign w_unused_upper = ^{addra[29:ADDR_WIDTH], addrb[29:ADDR_WIDTH]};
      end
   endgenerate

   generate
      for (genvar g = 0; g < c_LANES; g++) begin : g_lane
         logic [7:0] r_mem [c_DEPTH] = '{default: 8'h00};
         logic [7:0] r_rd_a;
         logic [7:0] r_rd_b;

         // Reads sample the array before this edge's writes land (read-first);
         // port B's write is issued last so it wins a same-lane collision.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rd_a <= 8'h00;
               r_rd_b <= 8'h00;
            end else begin
               r_rd_a <= r_mem[w_idx_a];
               r_rd_b <= r_mem[w_idx_b];
               if (wea[g]) begin
                  r_mem[w_idx_a] <= dina[8*g +: 8];
               end
               if (web[g]) begin
                  r_mem[w_idx_b] <= dinb[8*g +: 8];
               end
            end
         end

         assign douta[8*g +: 8] = r_rd_a;
         assign doutb[8*g +: 8] = r_rd_b;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_data_ram.sv
`default_nettype none
// Directed bench for data_ram: reference word model plus read-result scoreboard
// queues per port, with explicit checks of the documented example values.
module tb_data_ram;

   localparam int c_AW    = 12;
   localparam int c_DEPTH = 1 << c_AW;

   logic        clk;
   logic        rst_n;
   logic [3:0]  wea;
   logic [29:0] addra;
   logic [31:0] dina;
   logic [31:0] douta;
   logic [3:0]  web;
   logic [29:0] addrb;
   logic [31:0] dinb;
   logic [31:0] doutb;

   int n_checks;
   int n_fail;

   logic [31:0] model [c_DEPTH];
   logic [31:0] qa [$];
   logic [31:0] qb [$];

   data_ram #(.ADDR_WIDTH(c_AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .douta (douta),
      .web   (web),
      .addrb (addrb),
      .dinb  (dinb),
      .doutb (doutb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of traffic on both ports; expected read data comes from the model
   // before its update, then is compared after the edge.
   task automatic step(input logic [3:0] a_we, input logic [29:0] a_ad, input logic [31:0] a_d,
                       input logic [3:0] b_we, input logic [29:0] b_ad, input logic [31:0] b_d);
      int ia;
      int ib;
      ia = int'(a_ad[c_AW-1:0]);
      ib = int'(b_ad[c_AW-1:0]);
      qa.push_back(model[ia]);
      qb.push_back(model[ib]);
      for (int l = 0; l < 4; l++) if (a_we[l]) model[ia][8*l +: 8] = a_d[8*l +: 8];
      for (int l = 0; l < 4; l++) if (b_we[l]) model[ib][8*l +: 8] = b_d[8*l +: 8];
      wea = a_we; addra = a_ad; dina = a_d;
      web = b_we; addrb = b_ad; dinb = b_d;
      @(posedge clk);
      #1;
      chk("douta_sb", douta, qa.pop_front());
      chk("doutb_sb", doutb, qb.pop_front());
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < c_DEPTH; i++) model[i] = 32'h0;
      rst_n = 1'b0;
      wea = 4'h0; addra = '0; dina = '0;
      web = 4'h0; addrb = '0; dinb = '0;
      #12;
      chk("reset_douta", douta, 32'h0);
      chk("reset_doutb", doutb, 32'h0);
      rst_n = 1'b1;

      // Full-word write then read back
      step(4'hF, 30'd5, 32'hDEADBEEF, 4'h0, 30'd0, 32'h0);
      step(4'h0, 30'd5, 32'h0,        4'h0, 30'd5, 32'h0);
      chk("full_word_a", douta, 32'hDEADBEEF);
      chk("full_word_b", doutb, 32'hDEADBEEF);

      // Byte lanes
      step(4'hF,    30'd7, 32'h11223344, 4'h0, 30'd0, 32'h0);
      step(4'b0100, 30'd7, 32'h00AA0000, 4'h0, 30'd0, 32'h0);
      step(4'b0011, 30'd7, 32'h0000BBCC, 4'h0, 30'd7, 32'h0);
      chk("lane_mid_a", douta, 32'h11AA3344);
      step(4'h0,    30'd7, 32'h0,        4'h0, 30'd0, 32'h0);
      chk("lane_final", douta, 32'h11AABBCC);

      // Read-first and cross-port visibility
      step(4'hF, 30'd3, 32'h12345678, 4'h0, 30'd3, 32'h0);
      chk("rfirst_a", douta, 32'h0);
      chk("rfirst_b", doutb, 32'h0);
      step(4'h0, 30'd0, 32'h0, 4'h0, 30'd3, 32'h0);
      chk("cross_b", doutb, 32'h12345678);

      // Same-word collision: B wins lane 0
      step(4'hF, 30'd9, 32'hAAAAAAAA, 4'b0001, 30'd9, 32'hBBBBBBBB);
      step(4'h0, 30'd9, 32'h0, 4'h0, 30'd9, 32'h0);
      chk("collide", douta, 32'hAAAAAABB);

      // Disjoint lanes from both ports on one word
      step(4'b0011, 30'd10, 32'h00001111, 4'b1100, 30'd10, 32'h22220000);
      step(4'h0, 30'd10, 32'h0, 4'h0, 30'd10, 32'h0);
      chk("disjoint", doutb, 32'h22221111);

      // Address wrap-around
      step(4'hF, 30'(c_DEPTH + 1), 32'hCAFEF00D, 4'h0, 30'd0, 32'h0);
      step(4'h0, 30'd0, 32'h0, 4'h0, 30'd1, 32'h0);
      chk("wrap", doutb, 32'hCAFEF00D);

      // Reset mid-operation
      step(4'hF, 30'd4, 32'h55AA55AA, 4'h0, 30'd0, 32'h0);
      step(4'h0, 30'd4, 32'h0, 4'h0, 30'd4, 32'h0);
      chk("pre_rst_a", douta, 32'h55AA55AA);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_a", douta, 32'h0);
      chk("async_rst_b", doutb, 32'h0);
      wea = 4'hF; addra = 30'd4; dina = 32'hFFFFFFFF;
      web = 4'hF; addrb = 30'd4; dinb = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      chk("rst_hold_a", douta, 32'h0);
      chk("rst_hold_b", doutb, 32'h0);
      #2;
      wea = 4'h0; web = 4'h0;
      rst_n = 1'b1;
      #1;
      chk("post_rel_a", douta, 32'h0);
      step(4'h0, 30'd4, 32'h0, 4'h0, 30'd4, 32'h0);
      chk("preserved_a", douta, 32'h55AA55AA);
      chk("preserved_b", doutb, 32'h55AA55AA);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
